board_store: RTL and testbench

- Playfield memory of block types; the writer and owner side of the board-read interface the renderer uses.
- Renderer side: supplies a row/column selector and receives a 3-bit block type combinationally.
- Game-logic side: gets a valid/ready cell-write port, a collision probe port, and a line-clear engine.
- Line-clear engine: scans for full rows, shifts the rows above down, and reports the number of rows removed.

---
 rtl/tetris_pkg.sv | 16 +
 rtl/row_full_detect.sv | 22 ++
 rtl/board_store.sv | 153 +++++++++++++++
 tb/tb_board_store.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield types and constants.
// Block encoding and the line-clear sweep states.
package tetris_pkg;

  localparam int TYPE_W = 3;

  localparam logic [TYPE_W-1:0] BLOCK_EMPTY = '0;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/row_full_detect.sv
// Flags a row whose every cell holds a block.
// Purely combinational.
module row_full_detect
  import tetris_pkg::*;
#(
  parameter int N = 21,
  parameter int W = TYPE_W
) (
  input  logic [N*W-1:0] cells,
  output logic           full
);

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (cells[i*W +: W] == W'(BLOCK_EMPTY)) begin
        full = 1'b0;
      end
    end
  end

endmodule

// File: rtl/board_store.sv
// Playfield memory with renderer/probe reads, a cell write port
// and a bottom-up line-clear sweep.
module board_store
  import tetris_pkg::*;
#(
  parameter int BLOCKS_VERTICAL   = 12,
  parameter int BLOCKS_HORIZONTAL = 21
) (
  input  logic              clk_25_175,
  input  logic              reset,
  input  logic [4:0]        memselector_v,
  input  logic [4:0]        memselector_h,
  output logic [TYPE_W-1:0] blocktype_mem,
  input  logic [4:0]        probe_row,
  input  logic [4:0]        probe_col,
  output logic [TYPE_W-1:0] probe_type,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4:0]        wr_row,
  input  logic [4:0]        wr_col,
  input  logic [TYPE_W-1:0] wr_type,
  input  logic              clear_start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        lines_cleared
);

  localparam int BV = BLOCKS_VERTICAL;
  localparam int BH = BLOCKS_HORIZONTAL;
  localparam int RW = $clog2(BV);
  localparam int CW = $clog2(BH);
  localparam logic [4:0] ROWS = 5'(BV);
  localparam logic [4:0] COLS = 5'(BH);

  logic [TYPE_W-1:0] cells [BV][BH];

  state_t state, state_n;

  logic [RW-1:0] r;
  logic [RW-1:0] k;
  logic [4:0]    count;

  logic [BH*TYPE_W-1:0] row_bits;
  logic                 row_full;

  logic mem_ok, probe_ok, wr_ok;

  assign mem_ok   = (memselector_v < ROWS) && (memselector_h < COLS);
  assign probe_ok = (probe_row < ROWS) && (probe_col < COLS);
  assign wr_ok    = (wr_row < ROWS) && (wr_col < COLS);

  assign blocktype_mem = mem_ok
    ? cells[memselector_v[RW-1:0]][memselector_h[CW-1:0]]
    : BLOCK_EMPTY;

  assign probe_type = probe_ok
    ? cells[probe_row[RW-1:0]][probe_col[CW-1:0]]
    : BLOCK_EMPTY;

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    row_bits = '0;
    for (int c = 0; c < BH; c++) begin
      row_bits[c*TYPE_W +: TYPE_W] = cells[r][c];
    end
  end

  row_full_detect #(
    .N(BH),
    .W(TYPE_W)
  ) u_row_full (
    .cells(row_bits),
    .full (row_full)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (clear_start) state_n = CHECK;
      end
      CHECK: begin
        if (row_full)    state_n = SHIFT;
        else if (r == 0) state_n = DONE;
      end
      SHIFT: begin
        if (k == 0) state_n = CHECK;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_25_175) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk_25_175) begin
    if (reset) begin
      for (int i = 0; i < BV; i++) begin
        for (int j = 0; j < BH; j++) begin
          cells[i][j] <= BLOCK_EMPTY;
        end
      end
      r             <= '0;
      k             <= '0;
      count         <= '0;
      lines_cleared <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_valid && wr_ok) begin
            cells[wr_row[RW-1:0]][wr_col[CW-1:0]] <= wr_type;
          end
          if (clear_start) begin
            r     <= RW'(BV - 1);
            count <= '0;
          end
        end
        CHECK: begin
          if (row_full) begin
            if (count != 5'd31) count <= count + 5'd1;
            k <= r;
          end else if (r != 0) begin
            r <= r - 1'b1;
          end else begin
            lines_cleared <= count;
          end
        end
        SHIFT: begin
          // The row above drops in; row 0 refills empty on the last step.
          if (k != 0) begin
            for (int j = 0; j < BH; j++) begin
              cells[k][j] <= cells[k-1'b1][j];
            end
            k <= k - 1'b1;
          end else begin
            for (int j = 0; j < BH; j++) begin
              cells[0][j] <= BLOCK_EMPTY;
            end
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_store.sv
// Randomized and directed checks of board_store against a
// row-compaction reference model.
module tb_board_store;

  localparam int BV = 12;
  localparam int BH = 21;

  logic       clk_25_175 = 1'b0;
  logic       reset;
  logic [4:0] memselector_v, memselector_h;
  logic [2:0] blocktype_mem;
  logic [4:0] probe_row, probe_col;
  logic [2:0] probe_type;
  logic       wr_valid, wr_ready;
  logic [4:0] wr_row, wr_col;
  logic [2:0] wr_type;
  logic       clear_start, busy, done;
  logic [4:0] lines_cleared;

  int vectors = 0;
  int miscompares = 0;
  int model [BV][BH];

  always #20 clk_25_175 = ~clk_25_175;

  board_store dut (
    .clk_25_175   (clk_25_175),
    .reset        (reset),
    .memselector_v(memselector_v),
    .memselector_h(memselector_h),
    .blocktype_mem(blocktype_mem),
    .probe_row    (probe_row),
    .probe_col    (probe_col),
    .probe_type   (probe_type),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_type      (wr_type),
    .clear_start  (clear_start),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_25_175);
    #1;
  endtask

  task automatic write_cell(input int r, input int c, input int t);
    wr_row   = 5'(r);
    wr_col   = 5'(c);
    wr_type  = 3'(t);
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    if (r < BV && c < BH) model[r][c] = t;
  endtask

  task automatic read_at(input int r, input int c,
                         input int exp, input string tag);
    memselector_v = 5'(r);
    memselector_h = 5'(c);
    probe_row     = 5'(r);
    probe_col     = 5'(c);
    #2;
    check({tag, ":mem"}, 32'(blocktype_mem), 32'(exp));
    check({tag, ":probe"}, 32'(probe_type), 32'(exp));
  endtask

  task automatic check_board(input string tag);
    for (int r = 0; r < BV; r++) begin
      for (int c = 0; c < BH; c++) begin
        read_at(r, c, model[r][c], tag);
      end
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < BV; r++)
      for (int c = 0; c < BH; c++)
        model[r][c] = 0;
  endtask

  // Full rows vanish, survivors settle to the bottom in order.
  // Each removal costs one extra check plus (position+1) shifts,
  // where position is the row's original index moved down by the
  // number of full rows already removed beneath it.
  task automatic model_sweep(output int lines, output int lat);
    int nb [BV][BH];
    int dst;
    int shifts;
    bit full;
    dst = BV - 1;
    lines = 0;
    shifts = 0;
    for (int r = 0; r < BV; r++)
      for (int c = 0; c < BH; c++)
        nb[r][c] = 0;
    for (int o = BV - 1; o >= 0; o--) begin
      full = 1'b1;
      for (int c = 0; c < BH; c++)
        if (model[o][c] == 0) full = 1'b0;
      if (full) begin
        shifts += o + lines + 1;
        lines++;
      end else begin
        for (int c = 0; c < BH; c++) nb[dst][c] = model[o][c];
        dst--;
      end
    end
    model = nb;
    lat = 1 + BV + lines + shifts;
  endtask

  task automatic run_sweep(input string tag, input int exp_lines,
                           input int exp_lat, input bit poke,
                           input bit with_wr);
    int cyc;
    clear_start = 1'b1;
    if (with_wr) wr_valid = 1'b1;
    step();
    clear_start = 1'b0;
    wr_valid = 1'b0;
    check({tag, ":busy_rise"}, 32'(busy), 1);
    cyc = 1;
    while (!done && cyc < 400) begin
      if (poke && cyc == 3) begin
        check({tag, ":ready_low"}, 32'(wr_ready), 0);
        wr_row = 0;
        wr_col = 0;
        wr_type = 3'd7;
        wr_valid = 1'b1;
        clear_start = 1'b1;
      end
      step();
      wr_valid = 1'b0;
      clear_start = 1'b0;
      cyc++;
    end
    check({tag, ":latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, ":lines"}, 32'(lines_cleared), 32'(exp_lines));
    step();
    check({tag, ":done_once"}, 32'(done), 0);
    check({tag, ":idle"}, 32'(busy), 0);
    step();
    step();
    check({tag, ":no_resweep"}, 32'(busy), 0);
    check({tag, ":lines_held"}, 32'(lines_cleared), 32'(exp_lines));
  endtask

  task automatic fill_random(input int pfull);
    bit full;
    int hole;
    int t;
    for (int r = 0; r < BV; r++) begin
      full = ($urandom_range(0, 99) < pfull);
      hole = $urandom_range(0, BH - 1);
      for (int c = 0; c < BH; c++) begin
        if (full)           t = $urandom_range(1, 7);
        else if (c == hole) t = 0;
        else                t = $urandom_range(0, 7);
        write_cell(r, c, t);
      end
    end
  endtask

  initial begin
    int lines;
    int lat;
    reset = 1'b1;
    memselector_v = '0;
    memselector_h = '0;
    probe_row = '0;
    probe_col = '0;
    wr_valid = 1'b0;
    wr_row = '0;
    wr_col = '0;
    wr_type = '0;
    clear_start = 1'b0;
    clear_model();
    step();
    step();
    reset = 1'b0;
    check("rst:wr_ready", 32'(wr_ready), 1);
    check("rst:busy", 32'(busy), 0);
    check("rst:done", 32'(done), 0);
    check("rst:lines", 32'(lines_cleared), 0);
    check_board("rst");

    write_cell(3, 5, 4);
    check_board("single");
    read_at(12, 0, 0, "oor_row");
    read_at(0, 21, 0, "oor_col");
    read_at(19, 5, 0, "oor_alias");
    write_cell(3, 5, 0);

    for (int c = 0; c < BH; c++) write_cell(11, c, 2);
    write_cell(10, 0, 5);
    model_sweep(lines, lat);
    run_sweep("clear1", 1, 26, 1'b1, 1'b0);
    check_board("clear1");

    check("oor_wr:ready", 32'(wr_ready), 1);
    write_cell(12, 3, 1);
    check_board("oor_wr");

    for (int c = 0; c < BH; c++) begin
      write_cell(10, c, 3);
      write_cell(11, c, 6);
    end
    model_sweep(lines, lat);
    run_sweep("clear2", 2, 39, 1'b0, 1'b0);
    check_board("clear2");

    for (int c = 0; c < BH; c++)
      if (c != 7) write_cell(11, c, 1);
    wr_row = 5'd11;
    wr_col = 5'd7;
    wr_type = 3'd3;
    model[11][7] = 3;
    model_sweep(lines, lat);
    run_sweep("wr_and_clear", lines, lat, 1'b0, 1'b1);
    check_board("wr_and_clear");

    for (int n = 0; n < 5; n++) begin
      fill_random(45);
      model_sweep(lines, lat);
      run_sweep($sformatf("rand%0d", n), lines, lat, 1'b0, 1'b0);
      check_board($sformatf("rand%0d", n));
    end

    fill_random(100);
    model_sweep(lines, lat);
    run_sweep("all_full", BV, lat, 1'b0, 1'b0);
    check_board("all_full");

    for (int c = 0; c < BH; c++) write_cell(11, c, 4);
    write_cell(9, 2, 6);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    step();
    step();
    check("mid:busy", 32'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_model();
    check("mid_rst:busy", 32'(busy), 0);
    check("mid_rst:done", 32'(done), 0);
    check("mid_rst:lines", 32'(lines_cleared), 0);
    check("mid_rst:ready", 32'(wr_ready), 1);
    check_board("mid_rst");
    step();
    check("mid_rst:stay_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
